// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: owns HI/LO, models multi-cycle latency
// with a busy down-counter, and raises stall for dependent D-stage MDU ops.
//   state | meaning
//   IDLE  | no operation in flight; MTHI/MTLO and new MULT/DIV accepted
//   RUN   | result pending; counter runs down to the commit edge
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDout
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW    = $clog2(MAX_N + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   hi_q, lo_q, pend_hi, pend_lo;
  logic          pend_wr;

  logic          is_mult, is_div, start;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   divisor, q_s, r_s, q_u, r_u;
  logic          div_zero, div_ovf;
  logic [31:0]   res_hi, res_lo;

  assign is_mult = (E_op == 4'd1) || (E_op == 4'd2);
  assign is_div  = (E_op == 4'd3) || (E_op == 4'd4);
  assign start   = (state == IDLE) && (is_mult || is_div);

  // Divisor is forced to 1 on divide-by-zero so the datapath never sees X;
  // the result is discarded anyway via pend_wr.
  always_comb begin
    div_zero = (E_B == 32'd0);
    div_ovf  = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
    divisor  = div_zero ? 32'd1 : E_B;
    prod_s   = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    prod_u   = {32'd0, E_A} * {32'd0, E_B};
    q_s      = $signed(E_A) / $signed(divisor);
    r_s      = $signed(E_A) % $signed(divisor);
    q_u      = E_A / divisor;
    r_u      = E_A % divisor;
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    case (E_op)
      4'd1: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      4'd2: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      4'd3: begin
        res_hi = div_ovf ? 32'd0 : r_s;
        res_lo = div_ovf ? 32'h8000_0000 : q_s;
      end
      4'd4: begin res_hi = r_u; res_lo = q_u; end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (start) begin
        state_nx = RUN;
        cnt_nx   = is_mult ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
      end
      RUN: begin
        if (cnt != '0) cnt_nx = cnt - 1'b1;
        else           state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (start) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= !(is_div && div_zero);
    end else if (state == RUN) begin
      if (cnt == '0 && pend_wr) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
    end else if (E_op == 4'd5) begin
      hi_q <= E_A;
    end else if (E_op == 4'd6) begin
      lo_q <= E_A;
    end
  end

  assign busy    = (state == RUN);
  assign stall   = D_md_use & (busy | is_mult | is_div);
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign E_MDout = (E_op == 4'd7) ? hi_q : (E_op == 4'd8) ? lo_q : 32'd0;

endmodule
